// File: rtl/param_ring_buffer.sv
// Purpose: single-clock circular staging buffer with FIFO ordering and occupancy/full/empty status.
// Latency: first-word fall-through; a word written at edge N is on out after edge N if the buffer was empty.
// Backpressure: in_ready = ~full (independent of out_ready); out_valid = ~empty.
//
// Ports:
//   clock, reset          : clock; synchronous active-high reset
//   in_valid/in_ready/in  : write port (valid/ready), WORD_SIZE-bit data
//   out_valid/out_ready/out: read port (valid/ready), oldest stored word, 0 when empty
//   count                 : stored words, 0..DEPTH
//   full, empty           : derived from count
//   dropped               : one-cycle pulse after the edge at which the oldest word was overwritten
//
// Build option RING_BUFFER_OVERWRITE_EN: when defined, in_ready is tied 1. A write while full
// with no read stores the word and advances both heads, discarding the oldest entry.
// Without it, dropped is tied 0. The port list is the same in both builds.

module param_ring_buffer #(
    parameter int WORD_SIZE   = 4,
    parameter int DEPTH_POWER = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_SIZE-1:0]   in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_SIZE-1:0]   out,
    output logic [DEPTH_POWER:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic                   dropped
);

    localparam int DEPTH   = 1 << DEPTH_POWER;
    localparam int STORE_W = WORD_SIZE * DEPTH;
    localparam logic [DEPTH_POWER:0] DEPTH_CNT = (DEPTH_POWER + 1)'(DEPTH);

    // State
    logic [DEPTH_POWER-1:0] writer_head_q, writer_head_d;
    logic [DEPTH_POWER-1:0] reader_head_q, reader_head_d;
    logic [DEPTH_POWER:0]   count_q,       count_d;
    logic [STORE_W-1:0]     storage_q,     storage_d;

    // Handshake decode
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   drop_fire;
    logic [WORD_SIZE-1:0]   rd_word;

    // Status is taken from the occupancy counter, not from head comparison:
    // equal heads are ambiguous between full and empty.
    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign out_valid = ~empty;

`ifdef RING_BUFFER_OVERWRITE_EN
    assign in_ready  = 1'b1;
    // Overwrite only when nothing leaves this cycle; a coincident read makes
    // room and the write is an ordinary write+read.
    assign drop_fire = wr_fire & full & ~rd_fire;
`else
    assign in_ready  = ~full;
    assign drop_fire = 1'b0;
`endif

    assign wr_fire = in_valid & in_ready;
    assign rd_fire = out_valid & out_ready;

    // Read mux: select the slice at reader_head from the flat storage vector.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (reader_head_q == DEPTH_POWER'(i)) begin
                rd_word = storage_q[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Stale data stays in storage after a read; mask it so out reads 0 when empty.
    assign out = empty ? '0 : rd_word;

    // Next-state logic
    always_comb begin
        writer_head_d = writer_head_q;
        reader_head_d = reader_head_q;
        count_d       = count_q;
        storage_d     = storage_q;

        if (wr_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (writer_head_q == DEPTH_POWER'(i)) begin
                    storage_d[i*WORD_SIZE +: WORD_SIZE] = in;
                end
            end
            // Head width equals log2(DEPTH), so the increment wraps DEPTH-1 -> 0.
            writer_head_d = writer_head_q + 1'b1;
        end

        // A drop retires the oldest word exactly like a read does.
        if (rd_fire | drop_fire) begin
            reader_head_d = reader_head_q + 1'b1;
        end

        // An overwrite is a write paired with an implicit read: occupancy holds.
        unique case ({wr_fire & ~drop_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            writer_head_q <= '0;
            reader_head_q <= '0;
            count_q       <= '0;
            storage_q     <= '0;
        end else begin
            writer_head_q <= writer_head_d;
            reader_head_q <= reader_head_d;
            count_q       <= count_d;
            storage_q     <= storage_d;
        end
    end

`ifdef RING_BUFFER_OVERWRITE_EN
    logic dropped_q, dropped_d;

    always_comb begin
        dropped_d = drop_fire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped = dropped_q;
`else
    assign dropped = 1'b0;
`endif

endmodule

// File: tb/tb_param_ring_buffer.sv
// Purpose: randomized and directed stimulus against a queue-based reference of the ring buffer.
// Latency: monitor samples on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: writes are accepted in the model only when it holds fewer than DEPTH words (or always, in overwrite builds).

module tb_param_ring_buffer;

    localparam int W  = 4;
    localparam int DP = 3;
    localparam int D  = 1 << DP;

`ifdef RING_BUFFER_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_dat;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_dat;
    logic [DP:0]   count;
    logic          full;
    logic          empty;
    logic          dropped;

    param_ring_buffer #(.WORD_SIZE(W), .DEPTH_POWER(DP)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_dat),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .dropped   (dropped)
    );

    always #5 clock = ~clock;

    // Reference: the queue holds the stored words oldest-first.
    logic [W-1:0] sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;
    bit  exp_drop = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks visible status against the model, then retires the
    // handshakes that will happen at the coming rising edge.
    always @(negedge clock) begin
        int  sz;
        bit  rd;
        bit  wr;
        bit  drop;
        if (chk_en) begin
            sz = sb.size();
            chk("count",     int'(count),     sz);
            chk("full",      int'(full),      int'(sz == D));
            chk("empty",     int'(empty),     int'(sz == 0));
            chk("out_valid", int'(out_valid), int'(sz != 0));
            chk("in_ready",  int'(in_ready),  int'(OVERWRITE || sz < D));
            chk("out_idle",  int'(out_dat),   (sz == 0) ? 0 : int'(sb[0]));
            chk("dropped",   int'(dropped),   int'(exp_drop));

            rd   = (sz != 0) && out_ready;
            wr   = in_valid && (OVERWRITE || sz < D);
            drop = OVERWRITE && wr && (sz == D) && !rd;

            if (reset) begin
                sb.delete();
                exp_drop = 1'b0;
            end else begin
                if (rd) begin
                    chk("read_data", int'(out_dat), int'(sb[0]));
                    void'(sb.pop_front());
                end
                if (drop) void'(sb.pop_front());
                if (wr) sb.push_back(in_dat);
                exp_drop = drop;
            end
        end
    end

    task automatic cyc(input bit rst, input bit v, input logic [W-1:0] d, input bit r);
        reset     = rst;
        in_valid  = v;
        in_dat    = d;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    task automatic fill_1_to_8();
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, W'(i), 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int guard;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_dat    = '0;
        out_ready = 1'b0;

        // 1: reset for two cycles, then idle
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);

        // 2: fill 1..8 with no reads, then drain
        fill_1_to_8();
        cyc(1'b0, 1'b0, '0, 1'b0);
        drain(8);
        cyc(1'b0, 1'b0, '0, 1'b0);

        // 3: full + read + write attempt, then the write on the next cycle
        fill_1_to_8();
        cyc(1'b0, 1'b1, 4'hA, 1'b1);
        cyc(1'b0, 1'b1, 4'hA, 1'b0);
        drain(9);

        // 4: streaming with both sides always ready
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, W'($urandom), 1'b1);
        drain(2);

        // 5: reset during a write+read, then a fresh write
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, W'(i + 3), 1'b0);
        cyc(1'b1, 1'b1, 4'hF, 1'b1);
        cyc(1'b0, 1'b1, 4'h5, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);

`ifdef RING_BUFFER_OVERWRITE_EN
        // 6: overwrite the oldest word while full
        fill_1_to_8();
        cyc(1'b0, 1'b1, 4'h9, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        drain(8);
`endif

        // Randomized traffic with occasional resets and varying fill pressure
        for (int i = 0; i < 1500; i++) begin
            bit v;
            bit r;
            if (i < 500) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else if (i < 1000) begin
                v = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end else begin
                v = $urandom_range(0, 1) != 0;
                r = $urandom_range(0, 1) != 0;
            end
            cyc(($urandom_range(0, 199) == 0), v, W'($urandom), r);
        end

        // Final drain with a cycle bound
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            guard++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words left, expected 0", sb.size());
        end
        cyc(1'b0, 1'b0, '0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
